ay_psg_bus_regs: RTL and testbench
==================================

# ay_psg_bus_regs

Clocked AY-3-8910 bus-interface and register file, sitting directly downstream of the BK AY command decoder. It samples the raw BDIR/BC2/BC1 command lines and the 8-bit DA bus, then synchronises, deglitches and decodes them. It implements the address latch, the 16 PSG registers with per-register width masking, and read-back. Committed register writes are published as a one-cycle event stream for the tone, noise and envelope generators.

## Interface
- `FILT`, default 2: consecutive clocks a decoded bus state must be stable before it is accepted (1..15).
- `ADDR_HI`, default 4'h0: chip-select value compared against DA[7:4] during address latch.
- `clk` input 1: single system clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `bdir`, `bc2`, `bc1` input 1 each: raw, asynchronous AY bus command lines.
- `da_in` input 8: DA bus as driven by the CPU side.
- `da_out` output 8: read-back data.
- `da_oe` output 1: drive enable for `da_out`.
- `wr_stb` output 1: one-cycle pulse on each committed register write.
- `wr_addr` output 4: register index of the committed write, valid with `wr_stb`.
- `wr_data` output 8: masked data of the committed write, valid with `wr_stb`.
- `env_restart` output 1: one-cycle pulse, coincident with `wr_stb` when `wr_addr`=13.
- `cur_addr` output 4: currently latched register index.
- `selected` output 1: last address latch matched `ADDR_HI`.
- `regs_flat` output 128: R15..R0 concatenated, with R0 in bits [7:0].

## Operation
- **Synchronisation:** `bdir`, `bc2`, `bc1` and `da_in` each pass through two flip-flops.
- **Decode** of the synchronised {bdir,bc2,bc1}:
  - INACT: 000, 010, 101.
  - LADDR: 001, 100, 111.
  - READ: 011.
  - WRITE: 110.
- **Filter:**
  - The candidate state is the raw decode.
  - A counter increments while the candidate is unchanged and reloads to 1 on any change.
  - The accepted state `st` updates when the counter reaches `FILT`.
  - Shorter pulses, such as diode-gate glitches from the upstream stage, are ignored.
- **Data capture:** `dlast` holds the synchronised `da_in` from every cycle in which `st` is LADDR or WRITE.
- **Commit on exit:** actions fire on the cycle `st` leaves a state.
  - Leaving LADDR: `cur_addr`←`dlast`[3:0] and `selected`←(`dlast`[7:4]==`ADDR_HI`).
  - Leaving WRITE with `selected`=1: `regs[cur_addr]`←`dlast` & MASK[`cur_addr`]; pulse `wr_stb`; present `wr_addr`/`wr_data`; pulse `env_restart` if the index is 13.
  - Leaving WRITE with `selected`=0: no effect.
- **MASK** per register:
  - R0, R2, R4, R7, R11, R12, R14, R15: 8'hFF.
  - R1, R3, R5, R13: 8'h0F.
  - R6, R8, R9, R10: 8'h1F.
- **Read:** `da_oe`=1 exactly while `st`==READ and `selected`=1. `da_out`=`regs[cur_addr]` (already masked) whenever `da_oe`=1, otherwise 8'h00.
- **Back-to-back writes:** two WRITE periods with no state between them are impossible, because `st` must change. WRITE→LADDR commits the write first, then latches the new address on exit from LADDR.

## Timing
- **Reset** (`rst_n`=0 at a rising edge):
  - Cleared to 0: all registers, `cur_addr`, `selected`, `st`=INACT, filter counter, `dlast`, `da_out`, `da_oe`, `wr_stb`, `wr_addr`, `wr_data`, `env_restart`.
  - Reset during WRITE discards the pending write.
  - After reset release, the first state transition needs the full `FILT` qualification.
- **Latency, pin change to accepted `st`:** 2 (sync) + `FILT` clocks. With `FILT`=2, a pin change before edge k is accepted at edge k+4.
- **Latency, `st` leaving WRITE to outputs:** `wr_stb` and `regs_flat` update at the same edge as the `st` change (registered outputs, 0 extra cycles).
- **Read latency:** `da_oe` and `da_out` are registered with `st`; `da_out` tracks `cur_addr` in the same cycle.
- **Pulse width:** `wr_stb` and `env_restart` are high for exactly one clock per write.
- **Filter counter:** saturates at `FILT`.

## Structure
- **Package `ay_pkg`:** bus-state enum (INACT, LADDR, READ, WRITE), `REG_ENV_SHAPE`=13, and the 16-entry MASK constant array.
- **Sub-module `ay_cmd_filter`:** 2-FF synchroniser, decode and stability filter; outputs `st` and a one-cycle `st_exit` pulse with the previous state.
- **Top level:** data capture, address latch and register file.

## Test plan
- **Reset:** assert `rst_n`=0 with random pins -> `regs_flat`=0, `da_oe`=0, `cur_addr`=0, `selected`=0.
- **Write/read-back:** latch 8'h01, write 8'hFF, read -> `wr_stb` once, `wr_addr`=1, `wr_data`=8'h0F, `da_out`=8'h0F with `da_oe`=1.
- **Envelope restart:** write 8'h0A to R13 -> `env_restart` pulses once; R13 reads 8'h0A.
- **Glitch rejection:** with `FILT`=2, a 1-clock spike to 110 while idle at 101 -> no `wr_stb`; registers unchanged.
- **Chip select:** `ADDR_HI`=4'h0, latch 8'h35, then write 8'h55 -> `selected`=0, no `wr_stb`, `da_oe` stays 0 during READ.
- **Reset mid-write:** `rst_n` low while `st`=WRITE -> no commit; all outputs 0 on the next clock.

Source files
------------

// File: rtl/ay_pkg.sv
// AY PSG bus interface shared types: bus states, register masks,
// and the BDIR/BC2/BC1 command decode.
package ay_pkg;

  typedef enum logic [1:0] {
    ST_INACT = 2'd0,
    ST_LADDR = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } bus_st_t;

  localparam logic [3:0] REG_ENV_SHAPE = 4'd13;

  // Implemented bits per register, R15 leftmost.
  localparam logic [15:0][7:0] MASK = {
    8'hFF, 8'hFF, 8'h0F, 8'hFF,
    8'hFF, 8'h1F, 8'h1F, 8'h1F,
    8'hFF, 8'h1F, 8'h0F, 8'hFF,
    8'h0F, 8'hFF, 8'h0F, 8'hFF
  };

  function automatic bus_st_t decode(input logic [2:0] c);
    case (c)
      3'b001, 3'b100, 3'b111: decode = ST_LADDR;
      3'b011:                 decode = ST_READ;
      3'b110:                 decode = ST_WRITE;
      default:                decode = ST_INACT;
    endcase
  endfunction

endpackage

// File: rtl/ay_cmd_filter.sv
// Syncs the AY command lines and DA bus, decodes, and qualifies states.
// Ports: bdir/bc2/bc1/da_in raw in; st, st_exit, st_prev, da_s out.
module ay_cmd_filter
  import ay_pkg::*;
#(
  parameter int FILT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bdir,
  input  logic       bc2,
  input  logic       bc1,
  input  logic [7:0] da_in,
  output bus_st_t    st,
  output logic       st_exit,
  output bus_st_t    st_prev,
  output logic [7:0] da_s
);

  localparam logic [3:0] FILT_C = 4'(FILT);

  logic [2:0] p1, p2;
  logic [7:0] d1;
  logic [3:0] cnt, cnt_n;
  bus_st_t    raw, cand, cand_n, st_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1   <= '0;
      p2   <= '0;
      d1   <= '0;
      da_s <= '0;
      cand <= ST_INACT;
      cnt  <= '0;
      st   <= ST_INACT;
    end else begin
      p1   <= {bdir, bc2, bc1};
      p2   <= p1;
      d1   <= da_in;
      da_s <= d1;
      cand <= cand_n;
      cnt  <= cnt_n;
      st   <= st_n;
    end
  end

  // st_exit is combinational so commits land on the same edge as st.
  always_comb begin
    raw     = decode(p2);
    cand_n  = cand;
    cnt_n   = cnt;
    st_n    = st;
    st_exit = 1'b0;
    if (raw != cand) begin
      cand_n = raw;
      cnt_n  = 4'd1;
    end else if (cnt < FILT_C) begin
      cnt_n = cnt + 4'd1;
    end
    if (cnt == FILT_C && cand != st) begin
      st_n    = cand;
      st_exit = 1'b1;
    end
  end

  assign st_prev = st;

endmodule

// File: rtl/ay_psg_bus_regs.sv
// AY-3-8910 bus interface: address latch, masked register file, read-back.
// Ports: raw bus in; da_out/da_oe read-back; wr_* event stream; regs_flat.
module ay_psg_bus_regs
  import ay_pkg::*;
#(
  parameter int         FILT    = 2,
  parameter logic [3:0] ADDR_HI = 4'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bdir,
  input  logic         bc2,
  input  logic         bc1,
  input  logic [7:0]   da_in,
  output logic [7:0]   da_out,
  output logic         da_oe,
  output logic         wr_stb,
  output logic [3:0]   wr_addr,
  output logic [7:0]   wr_data,
  output logic         env_restart,
  output logic [3:0]   cur_addr,
  output logic         selected,
  output logic [127:0] regs_flat
);

  bus_st_t    st, st_prev;
  logic       st_exit;
  logic [7:0] da_s, dlast;
  logic [7:0] regs [16];

  ay_cmd_filter #(.FILT(FILT)) u_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .bdir    (bdir),
    .bc2     (bc2),
    .bc1     (bc1),
    .da_in   (da_in),
    .st      (st),
    .st_exit (st_exit),
    .st_prev (st_prev),
    .da_s    (da_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      cur_addr    <= '0;
      selected    <= 1'b0;
      dlast       <= '0;
      wr_stb      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      env_restart <= 1'b0;
    end else begin
      wr_stb      <= 1'b0;
      env_restart <= 1'b0;
      if (st == ST_LADDR || st == ST_WRITE)
        dlast <= da_s;
      if (st_exit) begin
        unique case (1'b1)
          st_prev == ST_LADDR: begin
            cur_addr <= dlast[3:0];
            selected <= dlast[7:4] == ADDR_HI;
          end
          st_prev == ST_WRITE && selected: begin
            regs[cur_addr] <= dlast & MASK[cur_addr];
            wr_stb         <= 1'b1;
            wr_addr        <= cur_addr;
            wr_data        <= dlast & MASK[cur_addr];
            env_restart    <= cur_addr == REG_ENV_SHAPE;
          end
          default: ;
        endcase
      end
    end
  end

  assign da_oe  = st == ST_READ && selected;
  assign da_out = da_oe ? regs[cur_addr] : 8'h00;

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < 16; i++)
      regs_flat[i*8 +: 8] = regs[i];
  end

endmodule

// File: tb/tb_ay_psg_bus_regs.sv
// Randomized self-checking bench for ay_psg_bus_regs.
// Compares against a register-file model driven by bus transactions.
module tb_ay_psg_bus_regs;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   pins = 3'b000;
  logic [7:0]   da = 8'h00;
  logic [7:0]   da_out;
  logic         da_oe;
  logic         wr_stb;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         env_restart;
  logic [3:0]   cur_addr;
  logic         selected;
  logic [127:0] regs_flat;

  int errs = 0;
  int checks = 0;
  int stb_cnt = 0;
  int env_cnt = 0;
  logic [3:0] last_addr = '0;
  logic [7:0] last_data = '0;

  logic [7:0] mregs [16];
  logic [3:0] maddr;
  logic       msel;

  ay_psg_bus_regs #(.FILT(2), .ADDR_HI(4'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bdir        (pins[2]),
    .bc2         (pins[1]),
    .bc1         (pins[0]),
    .da_in       (da),
    .da_out      (da_out),
    .da_oe       (da_oe),
    .wr_stb      (wr_stb),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .env_restart (env_restart),
    .cur_addr    (cur_addr),
    .selected    (selected),
    .regs_flat   (regs_flat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_stb) begin
      stb_cnt++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (env_restart) env_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mask_of(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13:  mask_of = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10:  mask_of = 8'h1F;
      default:                  mask_of = 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] idle_code();
    case ($urandom_range(2))
      0:       idle_code = 3'b000;
      1:       idle_code = 3'b010;
      default: idle_code = 3'b101;
    endcase
  endfunction

  function automatic logic [2:0] laddr_code();
    case ($urandom_range(2))
      0:       laddr_code = 3'b001;
      1:       laddr_code = 3'b100;
      default: laddr_code = 3'b111;
    endcase
  endfunction

  function automatic logic [127:0] mflat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = mregs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    maddr = 4'd0;
    msel  = 1'b0;
  endtask

  // Drive a command for a few clocks, then release to idle with DA held.
  task automatic bus_op(input logic [2:0] code, input logic [7:0] d);
    @(posedge clk); #1;
    pins = code;
    da   = d;
    repeat (6) @(posedge clk);
    #1 pins = idle_code();
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_laddr(input logic [7:0] d);
    bus_op(laddr_code(), d);
    maddr = d[3:0];
    msel  = d[7:4] == 4'h0;
    chk("cur_addr", 128'(cur_addr), 128'(maddr));
    chk("selected", 128'(selected), 128'(msel));
  endtask

  task automatic do_write(input logic [7:0] d);
    int s0, e0;
    logic [7:0] v;
    s0 = stb_cnt;
    e0 = env_cnt;
    bus_op(3'b110, d);
    v = d & mask_of(maddr);
    if (msel) mregs[maddr] = v;
    chk("wr_cnt", 128'(stb_cnt - s0), 128'(msel ? 1 : 0));
    chk("env_cnt", 128'(env_cnt - e0),
        128'((msel && maddr == 4'd13) ? 1 : 0));
    if (msel) begin
      chk("wr_addr", 128'(last_addr), 128'(maddr));
      chk("wr_data", 128'(last_data), 128'(v));
    end
    chk("regs_flat", regs_flat, mflat());
  endtask

  task automatic do_read();
    @(posedge clk); #1;
    pins = 3'b011;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("da_oe", 128'(da_oe), 128'(msel));
    chk("da_out", 128'(da_out), 128'(msel ? mregs[maddr] : 8'h00));
    @(posedge clk); #1;
    pins = idle_code();
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("da_oe_idle", 128'(da_oe), 128'(0));
  endtask

  initial begin
    int s0;
    model_reset();

    // Reset with noisy pins.
    repeat (4) begin
      @(posedge clk); #1;
      pins = 3'($urandom);
      da   = 8'($urandom);
    end
    @(negedge clk);
    chk("rst_regs", regs_flat, 128'(0));
    chk("rst_oe", 128'(da_oe), 128'(0));
    chk("rst_addr", 128'(cur_addr), 128'(0));
    chk("rst_sel", 128'(selected), 128'(0));
    chk("rst_stb", 128'(wr_stb), 128'(0));
    @(posedge clk); #1;
    pins  = 3'b000;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Write and read back through a masked register.
    do_laddr(8'h01);
    do_write(8'hFF);
    chk("wb_data", 128'(last_data), 128'(8'h0F));
    do_read();

    // Envelope shape write.
    do_laddr(8'h0D);
    do_write(8'h0A);
    do_read();

    // One-clock spike to WRITE while idling at 101.
    @(posedge clk); #1;
    pins = 3'b101;
    repeat (5) @(posedge clk);
    s0 = stb_cnt;
    #1 pins = 3'b110;
    @(posedge clk); #1;
    pins = 3'b101;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("glitch_stb", 128'(stb_cnt - s0), 128'(0));
    chk("glitch_regs", regs_flat, mflat());

    // Chip select miss.
    do_laddr(8'h35);
    do_write(8'h55);
    do_read();

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3))
        0: do_laddr(($urandom_range(4) == 0) ?
                    8'($urandom) : {4'h0, 4'($urandom)});
        1, 2: do_write(8'($urandom));
        default: do_read();
      endcase
    end

    // Reset while WRITE is the accepted state.
    do_laddr(8'h07);
    @(posedge clk); #1;
    pins = 3'b110;
    da   = 8'h3C;
    repeat (6) @(posedge clk);
    s0 = stb_cnt;
    #1;
    pins  = 3'b000;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("mw_regs", regs_flat, mflat());
    chk("mw_addr", 128'(cur_addr), 128'(0));
    chk("mw_sel", 128'(selected), 128'(0));
    chk("mw_oe", 128'(da_oe), 128'(0));
    chk("mw_wdata", 128'(wr_data), 128'(0));
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("mw_stb", 128'(stb_cnt - s0), 128'(0));
    chk("mw_regs2", regs_flat, mflat());

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
